// File: rtl/cordic_pkg.sv
// Shared CORDIC datapath constants and the normalizer state encoding.
// Also used by the arithmetic right shifter and the CORDIC iteration core.
package cordic_pkg;

  localparam int DATA_W    = 17;
  localparam int SHIFT_W   = $clog2(DATA_W);
  localparam int MAX_SHIFT = DATA_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/cordic_normalizer_if.sv
// Operand/result handshake bundle for cordic_normalizer.
// The master offers operands and takes results; the slave is the normalizer.
interface cordic_normalizer_if;
  import cordic_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [SHIFT_W-1:0] out_shift;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_shift
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_shift
  );

endinterface

// File: rtl/cordic_normalizer.sv
// Iterative left-shift normalizer: shifts a signed operand until its top two bits differ.
// Define NORM_FAST_EN to allow 2-bit steps when the top three bits agree.
module cordic_normalizer
  import cordic_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  cordic_normalizer_if.slave  bus
);

  state_t             r_state;
  logic [DATA_W-1:0]  r_data;
  logic [SHIFT_W-1:0] r_count;

  state_t             w_state_nxt;
  logic [DATA_W-1:0]  w_data_nxt;
  logic [SHIFT_W-1:0] w_count_nxt;
  logic               w_normalised;
  logic               w_at_max;

  assign w_normalised = r_data[DATA_W-1] ^ r_data[DATA_W-2];
  assign w_at_max     = (r_count == SHIFT_W'(MAX_SHIFT));

`ifdef NORM_FAST_EN
  logic w_fast_ok;
  // Three equal top bits mean the next single step would not stop either,
  // so two steps can be fused without overshooting the first sign change.
  assign w_fast_ok = (r_data[DATA_W-1] == r_data[DATA_W-2]) &&
                     (r_data[DATA_W-2] == r_data[DATA_W-3]) &&
                     (r_count <= SHIFT_W'(MAX_SHIFT - 2));
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_count_nxt = r_count;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_data_nxt  = bus.in_data;
          w_count_nxt = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_normalised || w_at_max) begin
          w_state_nxt = DONE;
        end
`ifdef NORM_FAST_EN
        else if (w_fast_ok) begin
          w_data_nxt  = {r_data[DATA_W-3:0], 2'b00};
          w_count_nxt = r_count + SHIFT_W'(2);
        end
`endif
        else begin
          w_data_nxt  = {r_data[DATA_W-2:0], 1'b0};
          w_count_nxt = r_count + SHIFT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_data;
  assign bus.out_shift = r_count;

endmodule
